// File: rtl/io_out_digit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_out_digit_ctrl
// Brief    : Two CPU-writable output ports shown as two BCD digits (value mod
//            100), converted by one shared bit-serial mod-100 engine.
// Revision : 1.0 - initial release
// ============================================================================
module io_out_digit_ctrl #(
  parameter logic [31:0] PORT0_ADDR = 32'h0000_0080,
  parameter logic [31:0] PORT1_ADDR = 32'h0000_0084
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] port0_q,
  output logic [31:0] port1_q,
  output logic [3:0]  dig1_1,
  output logic [3:0]  dig1_0,
  output logic [3:0]  dig2_1,
  output logic [3:0]  dig2_0,
  output logic        busy,
  output logic        upd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SPLIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pend0;
  logic        r_pend1;
  logic        r_last;
  logic        r_sel;
  logic [31:0] r_snap;
  logic [6:0]  r_rem;
  logic [4:0]  r_cnt;

  logic        w_st0;
  logic        w_st1;
  logic        w_load;
  logic        w_pick;
  logic [7:0]  w_t;
  logic        w_ge;
  logic [6:0]  w_sub;
  logic [3:0]  w_tens;
  logic [3:0]  w_tens_x10_lo;
  logic [3:0]  w_ones;

  assign w_st0  = we && (addr == PORT0_ADDR);
  assign w_st1  = we && (addr == PORT1_ADDR);
  assign w_load = (r_state == S_IDLE) && (r_pend0 || r_pend1);
  // Port 1 is picked when it is the only one pending, or on a tie after port 0 was served.
  assign w_pick = r_pend1 && (!r_pend0 || !r_last);

  // rem stays below 100, so t < 200 and at most one subtraction is needed per step.
  assign w_t   = {r_rem, r_snap[31]};
  assign w_ge  = (w_t >= 8'd100);
  assign w_sub = w_t[6:0] - 7'd100;

  always_comb begin
    w_tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (r_rem >= 7'(10 * k)) w_tens = 4'(k);
    end
  end

  // The ones digit is below 10, so only the low nibble of 10*tens matters.
  assign w_tens_x10_lo = {w_tens[0], 3'b000} + {w_tens[2:0], 1'b0};
  assign w_ones        = r_rem[3:0] - w_tens_x10_lo;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_next = S_CONV;
      S_CONV:  if (r_cnt == 5'd31) w_state_next = S_SPLIT;
      S_SPLIT: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      port0_q <= 32'd0;
      port1_q <= 32'd0;
      dig1_1  <= 4'd0;
      dig1_0  <= 4'd0;
      dig2_1  <= 4'd0;
      dig2_0  <= 4'd0;
      upd     <= 1'b0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_snap  <= 32'd0;
      r_rem   <= 7'd0;
      r_cnt   <= 5'd0;
    end else begin
      upd <= 1'b0;
      if (w_st0) port0_q <= datain;
      if (w_st1) port1_q <= datain;
      // A store on the load edge keeps the pend set so the new value converts later.
      r_pend0 <= w_st0 || (r_pend0 && !(w_load && !w_pick));
      r_pend1 <= w_st1 || (r_pend1 && !(w_load && w_pick));
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_sel  <= w_pick;
            r_last <= w_pick;
            r_snap <= w_pick ? port1_q : port0_q;
            r_rem  <= 7'd0;
            r_cnt  <= 5'd0;
          end
        end
        S_CONV: begin
          r_rem  <= w_ge ? w_sub : w_t[6:0];
          r_snap <= {r_snap[30:0], 1'b0};
          r_cnt  <= r_cnt + 5'd1;
        end
        S_SPLIT: begin
          if (r_sel) begin
            dig2_1 <= w_tens;
            dig2_0 <= w_ones;
          end else begin
            dig1_1 <= w_tens;
            dig1_0 <= w_ones;
          end
          upd <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_out_digit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_out_digit_ctrl
// Brief    : Directed self-checking bench for io_out_digit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_out_digit_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] datain = 32'd0;
  logic        we = 1'b0;
  logic [31:0] port0_q;
  logic [31:0] port1_q;
  logic [3:0]  dig1_1;
  logic [3:0]  dig1_0;
  logic [3:0]  dig2_1;
  logic [3:0]  dig2_0;
  logic        busy;
  logic        upd;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;

  io_out_digit_ctrl dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .port0_q (port0_q),
    .port1_q (port1_q),
    .dig1_1  (dig1_1),
    .dig1_0  (dig1_0),
    .dig2_1  (dig2_1),
    .dig2_0  (dig2_0),
    .busy    (busy),
    .upd     (upd)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (upd === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; the store lands on the following rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a; datain = d; we = w;
    @(negedge clock);
    we = 1'b0; addr = 32'd0; datain = 32'd0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(2);
    total++;
    if ({port0_q, port1_q} !== 64'd0) begin
      bad++; $display("FAIL reset_ports got=%h/%h want=0/0", port0_q, port1_q);
    end
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0, busy, upd} !== 18'd0) begin
      bad++; $display("FAIL reset_digits got=%h%h%h%h busy=%b upd=%b want all 0", dig1_1, dig1_0, dig2_1, dig2_0, busy, upd);
    end
    resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic();
    store(32'h80, 32'd1234, 1'b1);
    cyc(1);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=%b want=1", busy); end
    cyc(32);
    total++;
    if ({busy, upd, dig1_1, dig1_0} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL basic_before got busy=%b upd=%b dig=%h%h want busy=1 upd=0 dig=00", busy, upd, dig1_1, dig1_0);
    end
    cyc(1);
    total++;
    if ({upd, dig1_1, dig1_0, dig2_1, dig2_0} !== {1'b1, 16'h3400}) begin
      bad++; $display("FAIL basic_digits got upd=%b dig=%h%h/%h%h want upd=1 dig=34/00", upd, dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(1);
    total++;
    if ({busy, upd, port0_q} !== {2'b00, 32'd1234}) begin
      bad++; $display("FAIL basic_after got busy=%b upd=%b p0=%0d want busy=0 upd=0 p0=1234", busy, upd, port0_q);
    end
  endtask

  task automatic test_port1();
    store(32'h84, 32'hFFFF_FFFF, 1'b1);
    cyc(34);
    total++;
    if ({dig2_1, dig2_0, dig1_1, dig1_0, port1_q} !== {16'h9534, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL port1_max got dig2=%h%h dig1=%h%h p1=%h want 95/34 ffffffff", dig2_1, dig2_0, dig1_1, dig1_0, port1_q);
    end
    cyc(2);
    store(32'h84, 32'd7, 1'b1);
    cyc(34);
    total++;
    if ({dig2_1, dig2_0} !== 8'h07) begin bad++; $display("FAIL port1_7 got=%h%h want=07", dig2_1, dig2_0); end
    cyc(2);
    store(32'h84, 32'd100, 1'b1);
    cyc(34);
    total++;
    if ({upd, dig2_1, dig2_0} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL port1_100 got upd=%b dig=%h%h want upd=1 dig=00", upd, dig2_1, dig2_0);
    end
    cyc(2);
  endtask

  task automatic test_tie();
    apply_reset();
    // Port 1 occupies the engine while both ports become pending.
    store(32'h84, 32'd11, 1'b1);
    cyc(4);
    store(32'h80, 32'd56, 1'b1);
    store(32'h84, 32'd81, 1'b1);
    cyc(28);
    total++;
    if ({dig2_1, dig2_0, dig1_1, dig1_0} !== 16'h1100) begin
      bad++; $display("FAIL tie_a_first got=%h%h/%h%h want=00/11", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(34);
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h5611) begin
      bad++; $display("FAIL tie_a_port0_wins got=%h%h/%h%h want=56/11", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(34);
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h5681) begin
      bad++; $display("FAIL tie_a_port1_later got=%h%h/%h%h want=56/81", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(2);
    // Port 0 served last, so the next tie goes to port 1.
    store(32'h80, 32'd12, 1'b1);
    cyc(4);
    store(32'h84, 32'd23, 1'b1);
    store(32'h80, 32'd45, 1'b1);
    cyc(28);
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h1281) begin
      bad++; $display("FAIL tie_b_first got=%h%h/%h%h want=12/81", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(34);
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h1223) begin
      bad++; $display("FAIL tie_b_port1_wins got=%h%h/%h%h want=12/23", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(34);
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h4523) begin
      bad++; $display("FAIL tie_b_port0_later got=%h%h/%h%h want=45/23", dig1_1, dig1_0, dig2_1, dig2_0);
    end
    cyc(2);
  endtask

  task automatic test_restore();
    int base;
    store(32'h80, 32'd99, 1'b1);
    base = upd_cnt;
    cyc(9);
    store(32'h80, 32'd42, 1'b1);
    cyc(24);
    total++;
    if ({dig1_1, dig1_0} !== 8'h99) begin bad++; $display("FAIL restore_old got=%h%h want=99", dig1_1, dig1_0); end
    cyc(35);
    total++;
    if ({dig1_1, dig1_0, port0_q} !== {8'h42, 32'd42}) begin
      bad++; $display("FAIL restore_new got dig=%h%h p0=%0d want dig=42 p0=42", dig1_1, dig1_0, port0_q);
    end
    cyc(5);
    total++;
    if (upd_cnt - base !== 2) begin bad++; $display("FAIL restore_upd_count got=%0d want=2", upd_cnt - base); end
  endtask

  task automatic test_ignored();
    int base;
    base = upd_cnt;
    store(32'h88, 32'hDEAD_BEEF, 1'b1);
    store(32'h81, 32'hCAFE_F00D, 1'b1);
    store(32'h80, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ignored_busy cycle=%0d got=%b want=0", i, busy); end
      cyc(1);
    end
    total++;
    if ({port0_q, port1_q} !== {32'd42, 32'd23}) begin
      bad++; $display("FAIL ignored_ports got=%0d/%0d want=42/23", port0_q, port1_q);
    end
    total++;
    if ({dig1_1, dig1_0, dig2_1, dig2_0} !== 16'h4223 || upd_cnt != base) begin
      bad++; $display("FAIL ignored_digits got=%h%h/%h%h upds=%0d want=42/23 upds=0", dig1_1, dig1_0, dig2_1, dig2_0, upd_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    store(32'h80, 32'd1234, 1'b1);
    cyc(10);
    resetn = 1'b0;
    #1;
    total++;
    if ({port0_q, port1_q, dig1_1, dig1_0, dig2_1, dig2_0, busy, upd} !== 82'd0) begin
      bad++; $display("FAIL midreset_outputs got p=%h/%h dig=%h%h/%h%h busy=%b upd=%b want all 0", port0_q, port1_q, dig1_1, dig1_0, dig2_1, dig2_0, busy, upd);
    end
    cyc(3);
    resetn = 1'b1;
    base = upd_cnt;
    cyc(40);
    total++;
    if ({dig1_1, dig1_0, busy} !== 9'd0 || upd_cnt != base) begin
      bad++; $display("FAIL midreset_abort got dig=%h%h busy=%b upds=%0d want 00 0 0", dig1_1, dig1_0, busy, upd_cnt - base);
    end
    store(32'h80, 32'd1234, 1'b1);
    cyc(34);
    total++;
    if ({upd, dig1_1, dig1_0} !== {1'b1, 8'h34}) begin
      bad++; $display("FAIL midreset_fresh got upd=%b dig=%h%h want upd=1 dig=34", upd, dig1_1, dig1_0);
    end
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_port1();
    test_tie();
    test_restore();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
